// File: rtl/p2l_channel_arbiter_if.sv
// Handshake bundle of the pulse-to-level channel arbiter.
//   req_pulse   : one-cycle event request per requester
//   err_clr     : clears the sticky timeout flag
//   ack_level   : returned toggle level, already synchronized into clk1
//   tx_level    : toggle level driven into the crossing channel
//   tx_id       : index of the event in flight
//   busy        : arbiter is not idle
//   pend        : registered pending flags
//   done_pulse  : one-cycle completion strobe, one-hot at tx_id
//   timeout_err : sticky acknowledge-timeout flag
// The slave modport is the arbiter; the master modport is the requester/far side.
interface p2l_channel_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0] req_pulse;
  logic               err_clr;
  logic               ack_level;
  logic               tx_level;
  logic [ID_W-1:0]    tx_id;
  logic               busy;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] done_pulse;
  logic               timeout_err;

  modport slave (
    input  req_pulse, err_clr, ack_level,
    output tx_level, tx_id, busy, pend, done_pulse, timeout_err
  );

  modport master (
    output req_pulse, err_clr, ack_level,
    input  tx_level, tx_id, busy, pend, done_pulse, timeout_err
  );
endinterface

// File: rtl/p2l_channel_arbiter.sv
// Source-side controller sharing one toggle (pulse-to-level) crossing among
// NUM_REQ requesters. Request pulses are latched as pending flags, one is picked
// round-robin, launched by toggling tx_level, and the next launch waits until the
// returned ack_level matches. A stuck acknowledge raises a sticky timeout flag but
// never aborts the transfer.
//   clk1  : clock
//   reset : asynchronous active-low reset
//   bus   : slave side of p2l_channel_arbiter_if (requests, ack in; level, status out)
module p2l_channel_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                clk1,
  input  logic                reset,
  p2l_channel_arbiter_if.slave bus
);

  localparam int unsigned     TW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMAX      = TW'(ACK_TIMEOUT);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               tx_level_q, tx_level_d;
  logic [ID_W-1:0]    tx_id_q, tx_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] pend_q, pend_d, pend_clr;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               err_q, err_d, err_set;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic               hi_found, lo_found;
  logic [ID_W-1:0]    hi_idx, lo_idx;

  // Round-robin pick: lowest pending index above last_grant wins; otherwise wrap
  // around to the lowest pending index at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pend_q[i]) begin
        if (i > int'(last_grant_q)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = ID_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = ID_W'(i);
        end
      end
    end
    grant_valid = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d      = state_q;
    tx_level_d   = tx_level_q;
    tx_id_d      = tx_id_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    pend_clr     = '0;
    done_d       = '0;
    err_set      = 1'b0;

    case (state_q)
      IDLE: begin
        // ack_level is ignored here; only a launch can start a handshake.
        if (grant_valid) begin
          tx_level_d = ~tx_level_q;
          tx_id_d    = grant_idx;
          pend_clr   = NUM_REQ'(1) << grant_idx;
          timer_d    = '0;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.ack_level == tx_level_q) begin
          state_d = DONE;
          done_d  = NUM_REQ'(1) << tx_id_q;
        end else if (timer_q != TMAX) begin
          // Flag only on the cycle the timer arrives at the limit, so a clear
          // while still waiting is not immediately overridden.
          timer_d = timer_q + TW'(1);
          err_set = (timer_d == TMAX);
        end
      end
      DONE: begin
        last_grant_d = tx_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A request on the grant edge survives the clear: it is a new event.
  assign pend_d = (pend_q & ~pend_clr) | bus.req_pulse;
  assign err_d  = err_set | (err_q & ~bus.err_clr);

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tx_level_q   <= 1'b0;
      tx_id_q      <= '0;
      last_grant_q <= LAST_INIT;
      pend_q       <= '0;
      done_q       <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_level_q   <= tx_level_d;
      tx_id_q      <= tx_id_d;
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      done_q       <= done_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
    end
  end

  assign bus.tx_level    = tx_level_q;
  assign bus.tx_id       = tx_id_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.pend        = pend_q;
  assign bus.done_pulse  = done_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_p2l_channel_arbiter.sv
// Self-checking bench for p2l_channel_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_p2l_channel_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 8;

  logic clk1 = 1'b0;
  logic reset;

  p2l_channel_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

  p2l_channel_arbiter #(
    .NUM_REQ    (NR),
    .ID_W       (IW),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk1 (clk1),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial forever #5 clk1 = ~clk1;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = idle, 1 = waiting for ack, 2 = completion cycle.
  bit [NR-1:0] m_pend;
  int          m_phase;
  bit          m_lvl;
  int          m_id;
  int          m_last;
  int          m_wait;
  bit          m_err;

  // Far-side echo and observation logs.
  bit ack_hold;
  int ack_delay;
  int ack_cnt;
  bit prev_lvl;
  int launches[$];
  int lvls[$];
  int dones[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pend  = '0;
    m_phase = 0;
    m_lvl   = 1'b0;
    m_id    = 0;
    m_last  = NR - 1;
    m_wait  = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    bit [NR-1:0] clr = '0;
    bit          eset = 1'b0;
    case (m_phase)
      0: begin
        if (m_pend != 0) begin
          for (int k = 1; k <= NR; k++) begin
            int c = (m_last + k) % NR;
            if (m_pend[c]) begin
              m_id    = c;
              clr[c]  = 1'b1;
              m_lvl   = ~m_lvl;
              m_wait  = 0;
              m_phase = 1;
              break;
            end
          end
        end
      end
      1: begin
        if (bus.ack_level == m_lvl) m_phase = 2;
        else begin
          m_wait++;
          if (m_wait == TO) eset = 1'b1;
        end
      end
      default: begin
        m_last  = m_id;
        m_phase = 0;
      end
    endcase
    m_pend = (m_pend & ~clr) | bus.req_pulse;
    m_err  = eset | (m_err & !bus.err_clr);
  endtask

  task automatic compare_all();
    int exp_done;
    exp_done = (m_phase == 2) ? (1 << m_id) : 0;
    check("tx_level", int'(bus.tx_level), int'(m_lvl));
    check("tx_id", int'(bus.tx_id), m_id);
    check("busy", int'(bus.busy), int'(m_phase != 0));
    check("pend", int'(bus.pend), int'(m_pend));
    check("done_pulse", int'(bus.done_pulse), exp_done);
    check("timeout_err", int'(bus.timeout_err), int'(m_err));
  endtask

  task automatic tick();
    @(posedge clk1);
    if (!reset) m_reset();
    else model_step();
    @(negedge clk1);
    compare_all();
    if (bus.tx_level !== prev_lvl) begin
      launches.push_back(int'(bus.tx_id));
      lvls.push_back(int'(bus.tx_level));
      prev_lvl = bus.tx_level;
    end
    if (bus.done_pulse != 0) dones.push_back(int'(bus.done_pulse));
    if (!ack_hold && reset) begin
      if (bus.ack_level != bus.tx_level) begin
        if (ack_cnt >= ack_delay) begin
          bus.ack_level = bus.tx_level;
          ack_cnt = 0;
        end else ack_cnt++;
      end else ack_cnt = 0;
    end
  endtask

  // Asserts reset mid-cycle, checks outputs right away, then releases it.
  task automatic do_reset();
    bus.req_pulse = '0;
    bus.err_clr   = 1'b0;
    #2;
    reset         = 1'b0;
    bus.ack_level = 1'b0;
    ack_cnt       = 0;
    #1;
    m_reset();
    prev_lvl = 1'b0;
    compare_all();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.req_pulse = '0;
    bus.err_clr   = 1'b0;
    bus.ack_level = 1'b0;
    ack_hold      = 1'b1;
    ack_delay     = 0;
    ack_cnt       = 0;
    prev_lvl      = 1'b0;
    m_reset();
    tick();
    tick();
    check("reset_pend", int'(bus.pend), 0);
    check("reset_busy", int'(bus.busy), 0);
    reset = 1'b1;

    // Single event, manual ack.
    tick();
    tick();
    bus.req_pulse = 4'b0100;
    tick();
    bus.req_pulse = '0;
    check("t1_pend", int'(bus.pend), 4);
    check("t1_idle", int'(bus.busy), 0);
    tick();
    check("t1_level", int'(bus.tx_level), 1);
    check("t1_id", int'(bus.tx_id), 2);
    check("t1_busy", int'(bus.busy), 1);
    tick();
    tick();
    bus.ack_level = 1'b1;
    tick();
    check("t1_done", int'(bus.done_pulse), 4);
    check("t1_done_busy", int'(bus.busy), 1);
    tick();
    check("t1_after_busy", int'(bus.busy), 0);
    check("t1_after_done", int'(bus.done_pulse), 0);

    // Three simultaneous requests with immediate echo.
    do_reset();
    ack_hold  = 1'b0;
    ack_delay = 0;
    launches.delete();
    lvls.delete();
    dones.delete();
    bus.req_pulse = 4'b1011;
    tick();
    bus.req_pulse = '0;
    for (int i = 0; i < 20; i++) tick();
    check("t2_nlaunch", launches.size(), 3);
    check("t2_ndone", dones.size(), 3);
    if (launches.size() == 3 && lvls.size() == 3 && dones.size() == 3) begin
      check("t2_id0", launches[0], 0);
      check("t2_id1", launches[1], 1);
      check("t2_id2", launches[2], 3);
      check("t2_lvl0", lvls[0], 1);
      check("t2_lvl1", lvls[1], 0);
      check("t2_lvl2", lvls[2], 1);
      check("t2_done0", dones[0], 1);
      check("t2_done1", dones[1], 2);
      check("t2_done2", dones[2], 8);
    end

    // Round-robin after grant 1.
    bus.req_pulse = 4'b0010;
    tick();
    bus.req_pulse = '0;
    for (int i = 0; i < 8; i++) tick();
    launches.delete();
    bus.req_pulse = 4'b0101;
    tick();
    bus.req_pulse = '0;
    for (int i = 0; i < 15; i++) tick();
    check("t3_nlaunch", launches.size(), 2);
    check("t3_first", (launches.size() > 0) ? launches[0] : -1, 2);
    check("t3_second", (launches.size() > 1) ? launches[1] : -1, 0);

    // Acknowledge timeout.
    ack_hold = 1'b1;
    bus.req_pulse = 4'b0001;
    tick();
    bus.req_pulse = '0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("t4_err_before", int'(bus.timeout_err), 0);
    tick();
    check("t4_err_set", int'(bus.timeout_err), 1);
    check("t4_busy", int'(bus.busy), 1);
    for (int i = 0; i < 3; i++) tick();
    check("t4_still_busy", int'(bus.busy), 1);
    bus.ack_level = bus.tx_level;
    tick();
    check("t4_late_done", int'(bus.done_pulse), 1);
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t4_err_clr", int'(bus.timeout_err), 0);
    bus.req_pulse = 4'b0010;
    tick();
    bus.req_pulse = '0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t4_set_wins", int'(bus.timeout_err), 1);
    ack_hold  = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 5; i++) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // Coalescing while pending.
    ack_hold = 1'b1;
    bus.req_pulse = 4'b0010;
    tick();
    bus.req_pulse = '0;
    tick();
    bus.req_pulse = 4'b0001;
    tick();
    bus.req_pulse = '0;
    tick();
    bus.req_pulse = 4'b0001;
    tick();
    bus.req_pulse = '0;
    check("t5_pend", int'(bus.pend), 1);
    launches.delete();
    ack_hold = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("t5_nlaunch", launches.size(), 1);
    check("t5_id", (launches.size() > 0) ? launches[0] : -1, 0);

    // Request on the launch edge of the same requester.
    ack_hold = 1'b1;
    bus.req_pulse = 4'b0001;
    tick();
    tick();
    bus.req_pulse = '0;
    check("t5_le_id", int'(bus.tx_id), 0);
    check("t5_le_busy", int'(bus.busy), 1);
    check("t5_le_pend", int'(bus.pend), 1);
    launches.delete();
    ack_hold = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("t5_le_nlaunch", launches.size(), 1);
    check("t5_le_id2", (launches.size() > 0) ? launches[0] : -1, 0);

    // Reset during WAIT_ACK with other requests pending.
    ack_hold = 1'b1;
    bus.req_pulse = 4'b0001;
    tick();
    bus.req_pulse = '0;
    tick();
    bus.req_pulse = 4'b1010;
    tick();
    bus.req_pulse = '0;
    check("t6_pend", int'(bus.pend), 10);
    check("t6_busy", int'(bus.busy), 1);
    #2;
    reset         = 1'b0;
    bus.ack_level = 1'b0;
    ack_cnt       = 0;
    #1;
    m_reset();
    prev_lvl = 1'b0;
    compare_all();
    check("t6_rst_pend", int'(bus.pend), 0);
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_level", int'(bus.tx_level), 0);
    tick();
    tick();
    reset = 1'b1;
    dones.delete();
    ack_hold = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t6_no_done", dones.size(), 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.req_pulse = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
      bus.err_clr   = ($urandom_range(0, 15) == 0);
      if (!bus.busy)
        ack_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 4);
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end
    bus.req_pulse = '0;
    bus.err_clr   = 1'b0;
    ack_delay     = 0;
    for (int i = 0; i < 40; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/p2l_channel_arbiter.md
Name: p2l_channel_arbiter

Overview:
- Source-side controller that shares one pulse-to-level (toggle) crossing channel among NUM_REQ requesters in the clk1 domain.
- Captures single-cycle event pulses and selects one pending event round-robin.
- Launches the selected event by toggling tx_level, then holds off the next launch until the far side's returned toggle (ack_level, already 2-FF synchronized into clk1) matches.
- Reports per-requester completion and a sticky acknowledge-timeout error.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of tx_id; must be >= clog2(NUM_REQ)
ACK_TIMEOUT, 255, WAIT_ACK cycles before timeout_err is raised (>= 1)

Ports:
clk1  input  1  single clock
reset  input  1  asynchronous, active-low reset
req_pulse  input  NUM_REQ  one-cycle event request per requester
err_clr  input  1  clears timeout_err
ack_level  input  1  returned toggle level from the far domain, pre-synchronized
tx_level  output  1  toggle level driven into the crossing channel
tx_id  output  ID_W  index of the event in flight; stable while busy
busy  output  1  high when state != IDLE
pend  output  NUM_REQ  registered pending flags
done_pulse  output  NUM_REQ  one-cycle completion strobe, indexed by tx_id
timeout_err  output  1  sticky acknowledge-timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tx_level=0; tx_id=0; pend=0; done_pulse=0; timeout_err=0; timer=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- pend[i]:
  - Set at the edge sampling req_pulse[i]=1.
  - Cleared when granted.
  - Set wins over a same-edge grant clear: the new event stays pending.
  - A pulse while pend[i]=1 is coalesced into the existing pending event; no count is kept.
- FSM states: IDLE, WAIT_ACK, DONE.
  - IDLE with pend != 0: grant = first set pend bit scanning from (last_grant+1) mod NUM_REQ upward, wrapping. At that edge: tx_level toggles; tx_id <= grant; pend[grant] cleared; timer <= 0; state -> WAIT_ACK.
  - IDLE with pend == 0: hold. Any ack_level mismatch in IDLE is ignored.
  - WAIT_ACK: if ack_level == tx_level at an edge -> DONE. Otherwise timer increments, saturating at ACK_TIMEOUT. When timer reaches ACK_TIMEOUT, timeout_err sets. The block keeps waiting after a timeout: no abort, no re-toggle.
  - DONE (exactly 1 cycle): done_pulse[tx_id]=1, all other bits 0; last_grant <= tx_id; state -> IDLE.
- Minimum latency:
  - req_pulse sampled at edge N -> pend at N -> tx_level toggles at edge N+1.
  - Ack matching at edge M -> done_pulse high for the cycle after M.
  - Back-to-back events are spaced at least 3 cycles apart (IDLE, WAIT_ACK, DONE).
- Stability: tx_id and tx_level change only on launch.
- timeout_err: cleared by err_clr=1. If set and clear occur on the same edge, set wins.
- Timer width: clog2(ACK_TIMEOUT+1).
- Reset mid-operation: all state returns to reset values. Pending and in-flight events are discarded; no done_pulse is issued for them.

Test Plan:
- Release reset, pulse req_pulse=4'b0100 at edge 3 -> tx_level 0->1 at edge 4, tx_id=2, busy=1; set ack_level=1 at edge 7 -> done_pulse=4'b0100 for one cycle after edge 7, then busy=0.
- Single-cycle req_pulse=4'b1011 -> launches in order tx_id 0,1,3; tx_level toggles 1,0,1; done_pulse order 0001, 0010, 1000 with immediate echo acks.
- Round-robin: after grant 1 completes, raise pend[0] and pend[2] together -> grant 2 first, then 0.
- ACK_TIMEOUT=8, hold ack_level stale -> timeout_err=1 on the 8th WAIT_ACK cycle, busy stays 1; later ack -> done_pulse still fires; err_clr -> timeout_err=0; err_clr on the same edge as a new timeout -> stays 1.
- req_pulse[0] twice while pending -> one launch only; req_pulse[0] on the launch edge of requester 0 -> pend[0] stays 1 and a second launch follows.
- Assert reset during WAIT_ACK with pend=4'b1010 -> all outputs at reset values immediately; no done_pulse after release.
